// File: rtl/order_content_pkg.sv
// Shared widths and the response-entry type for the order-content RAM access path.
package order_content_pkg;

    localparam int ORDER_SLOTS  = 4096;
    localparam int ORDER_ADDR_W = $clog2(ORDER_SLOTS);
    localparam int ORDER_DATA_W = 241;

    typedef struct packed {
        logic [ORDER_ADDR_W-1:0] addr;
        logic [ORDER_DATA_W-1:0] data;
    } rsp_entry_t;

endpackage

// File: rtl/order_rsp_fifo.sv
// First-word-fall-through FIFO of lookup responses; head reads as zero while empty.
module order_rsp_fifo
    import order_content_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  rsp_entry_t       push_entry,
    input  logic             pop,
    output rsp_entry_t       head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    rsp_entry_t       mem_q [DEPTH];
    rsp_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/order_content_rd_ctrl.sv
// Order-content RAM access controller: writes win the single port, lookups return via a credit-protected response FIFO.
// Define ORDER_RD_STATS_EN to build the stat_* counters; otherwise those ports read 0.
module order_content_rd_ctrl
    import order_content_pkg::*;
#(
    parameter int ADDR_W     = ORDER_ADDR_W,
    parameter int DATA_W     = ORDER_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              axis_aclk,
    input  logic              axis_resetn,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic [31:0]       stat_rd_cnt,
    output logic [31:0]       stat_wr_cnt,
    output logic [31:0]       stat_stall_cnt
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);

    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    used_credits;
    logic              rd_accept;
    logic              fifo_push, fifo_pop;
    rsp_entry_t        push_entry, head_entry;

    // Credits count only registered occupancy, so a pop frees its slot one cycle later.
    always_comb begin
        used_credits = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
        wr_ready     = axis_resetn;
        req_ready    = axis_resetn && !wr_valid && (used_credits < DEPTH_V);
        rd_accept    = req_valid && req_ready;
        inflight_d   = rd_accept;
        tag_d        = rd_accept ? req_addr : tag_q;
    end

    always_comb begin
        ram_we   = wr_valid;
        ram_addr = wr_valid ? wr_addr : req_addr;
        ram_din  = wr_valid ? wr_data : '0;
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            inflight_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
        end
    end

    // Only a lookup issued last cycle owns ram_dout; write-through data is dropped.
    always_comb begin
        fifo_push       = inflight_q;
        push_entry.addr = tag_q;
        push_entry.data = ram_dout;
        fifo_pop        = rsp_valid && rsp_ready;
    end

    order_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_rsp_fifo (
        .clk        (axis_aclk),
        .rst_n      (axis_resetn),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (head_entry),
        .count      (fifo_count)
    );

    assign rsp_valid = (fifo_count != '0);
    assign rsp_addr  = head_entry.addr;
    assign rsp_data  = head_entry.data;

`ifdef ORDER_RD_STATS_EN
    logic [31:0] stat_rd_cnt_q, stat_rd_cnt_d;
    logic [31:0] stat_wr_cnt_q, stat_wr_cnt_d;
    logic [31:0] stat_stall_cnt_q, stat_stall_cnt_d;

    // Saturating event counters.
    always_comb begin
        stat_rd_cnt_d    = stat_rd_cnt_q;
        stat_wr_cnt_d    = stat_wr_cnt_q;
        stat_stall_cnt_d = stat_stall_cnt_q;
        if (rd_accept && (stat_rd_cnt_q != 32'hFFFF_FFFF)) begin
            stat_rd_cnt_d = stat_rd_cnt_q + 32'd1;
        end
        if (wr_valid && wr_ready && (stat_wr_cnt_q != 32'hFFFF_FFFF)) begin
            stat_wr_cnt_d = stat_wr_cnt_q + 32'd1;
        end
        if (req_valid && !req_ready && (stat_stall_cnt_q != 32'hFFFF_FFFF)) begin
            stat_stall_cnt_d = stat_stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            stat_rd_cnt_q    <= '0;
            stat_wr_cnt_q    <= '0;
            stat_stall_cnt_q <= '0;
        end else begin
            stat_rd_cnt_q    <= stat_rd_cnt_d;
            stat_wr_cnt_q    <= stat_wr_cnt_d;
            stat_stall_cnt_q <= stat_stall_cnt_d;
        end
    end

    assign stat_rd_cnt    = stat_rd_cnt_q;
    assign stat_wr_cnt    = stat_wr_cnt_q;
    assign stat_stall_cnt = stat_stall_cnt_q;
`else
    assign stat_rd_cnt    = '0;
    assign stat_wr_cnt    = '0;
    assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_order_content_rd_ctrl.sv
// Self-checking bench for order_content_rd_ctrl with a behavioural RAM and a slot-content reference model.
module tb_order_content_rd_ctrl;

    localparam int AW    = 12;
    localparam int DW    = 241;
    localparam int DEPTH = 4;

`ifdef ORDER_RD_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic          axis_aclk = 1'b0;
    logic          axis_resetn = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;
    logic [31:0]   stat_rd_cnt, stat_wr_cnt, stat_stall_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          exp_q[$];
    rsp_t          obs_q[$];
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] ram_mem [int];
    int            n_wr = 0, n_rd = 0, n_stall = 0;

    order_content_rd_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .axis_aclk      (axis_aclk),
        .axis_resetn    (axis_resetn),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .ram_addr       (ram_addr),
        .ram_din        (ram_din),
        .ram_we         (ram_we),
        .ram_dout       (ram_dout),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_addr       (rsp_addr),
        .rsp_data       (rsp_data),
        .stat_rd_cnt    (stat_rd_cnt),
        .stat_wr_cnt    (stat_wr_cnt),
        .stat_stall_cnt (stat_stall_cnt)
    );

    always #5 axis_aclk = ~axis_aclk;

    // Synchronous single-port RAM, write-through on write cycles, unwritten slots read 0.
    always @(posedge axis_aclk) begin
        if (ram_we) begin
            ram_dout <= ram_din;
            ram_mem[int'(ram_addr)] = ram_din;
        end else begin
            ram_dout <= ram_mem.exists(int'(ram_addr)) ? ram_mem[int'(ram_addr)] : '0;
        end
    end

    // Reference model: slot contents plus expected/observed response streams and event counts.
    always @(negedge axis_aclk) begin
        rsp_t e;
        if (!axis_resetn) begin
            exp_q.delete();
            obs_q.delete();
            n_wr = 0; n_rd = 0; n_stall = 0;
        end else begin
            if (wr_valid) begin
                ref_mem[int'(wr_addr)] = wr_data;
                n_wr++;
            end
            if (req_valid && req_ready) begin
                e.addr = req_addr;
                e.data = ref_mem.exists(int'(req_addr)) ? ref_mem[int'(req_addr)] : '0;
                exp_q.push_back(e);
                n_rd++;
            end
            if (req_valid && !req_ready) n_stall++;
            if (rsp_valid && rsp_ready) begin
                e.addr = rsp_addr;
                e.data = rsp_data;
                obs_q.push_back(e);
            end
        end
    end

    function automatic logic [DW-1:0] rand_data();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return w[DW-1:0];
    endfunction

    task automatic step();
        @(posedge axis_aclk);
        #1;
    endtask

    task automatic test_reset();
        axis_resetn = 1'b0;
        wr_valid = 1'b0; req_valid = 1'b1; req_addr = 12'h0AB; rsp_ready = 1'b1;
        @(negedge axis_aclk);
        total++; if (wr_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_wr_ready got=%b exp=0", wr_ready); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_req_ready got=%b exp=0", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_addr !== '0) begin bad++; $display("[TB] FAIL rst_rsp_addr got=%h exp=0", rsp_addr); end
        total++; if (rsp_data !== '0) begin bad++; $display("[TB] FAIL rst_rsp_data got=%h exp=0", rsp_data); end
        total++; if ({stat_rd_cnt, stat_wr_cnt, stat_stall_cnt} !== 96'd0) begin
            bad++; $display("[TB] FAIL rst_stats got=%0d/%0d/%0d exp=0/0/0", stat_rd_cnt, stat_wr_cnt, stat_stall_cnt);
        end
        req_valid = 1'b0;
        step();
        axis_resetn = 1'b1;
        @(negedge axis_aclk);
        total++; if (wr_ready !== 1'b1) begin bad++; $display("[TB] FAIL run_wr_ready got=%b exp=1", wr_ready); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL run_req_ready got=%b exp=1", req_ready); end
        total++; if (ram_we !== 1'b0 || ram_addr !== 12'h0AB || ram_din !== '0) begin
            bad++; $display("[TB] FAIL idle_ram_drive got we=%b addr=%h din=%h exp we=0 addr=0ab din=0", ram_we, ram_addr, ram_din);
        end
        step();
    endtask

    task automatic test_write_then_read();
        logic [DW-1:0] a;
        a = rand_data();
        rsp_ready = 1'b1;
        wr_valid = 1'b1; wr_addr = 12'h005; wr_data = a;
        @(negedge axis_aclk);
        total++; if (ram_we !== 1'b1 || ram_addr !== 12'h005 || ram_din !== a) begin
            bad++; $display("[TB] FAIL wr_ram_drive got we=%b addr=%h din=%h exp we=1 addr=005 din=%h", ram_we, ram_addr, ram_din, a);
        end
        total++; if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL wr_blocks_req got=%b exp=0", req_ready); end
        step();
        wr_valid = 1'b0; req_valid = 1'b1; req_addr = 12'h005;
        @(negedge axis_aclk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL raw_accept got=%b exp=1", req_ready); end
        step();
        req_valid = 1'b0;
        @(negedge axis_aclk);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL raw_lat1_valid got=%b exp=0", rsp_valid); end
        step();
        @(negedge axis_aclk);
        total++; if (rsp_valid !== 1'b1 || rsp_addr !== 12'h005 || rsp_data !== a) begin
            bad++; $display("[TB] FAIL raw_rsp got v=%b addr=%h data=%h exp v=1 addr=005 data=%h", rsp_valid, rsp_addr, rsp_data, a);
        end
        step();
        @(negedge axis_aclk);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL raw_drained got=%b exp=0", rsp_valid); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d [16];
        logic [AW-1:0] ea;
        for (int i = 0; i < 16; i++) begin
            d[i] = rand_data();
            wr_valid = 1'b1; wr_addr = AW'(32'h10 + i); wr_data = d[i];
            step();
        end
        wr_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 18; c++) begin
            req_valid = (c < 16);
            req_addr  = AW'(32'h10 + c);
            @(negedge axis_aclk);
            if (c < 16) begin
                total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready c=%0d got=%b exp=1", c, req_ready); end
            end
            if (c >= 2) begin
                ea = AW'(32'h10 + c - 2);
                total++; if (rsp_valid !== 1'b1 || rsp_addr !== ea || rsp_data !== d[c-2]) begin
                    bad++; $display("[TB] FAIL b2b_rsp c=%0d got v=%b addr=%h data=%h exp v=1 addr=%h data=%h",
                                    c, rsp_valid, rsp_addr, rsp_data, ea, d[c-2]);
                end
            end
            step();
        end
        req_valid = 1'b0;
        @(negedge axis_aclk);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_tail got=%b exp=0", rsp_valid); end
        step();
    endtask

    task automatic test_backpressure();
        int            issued = 0;
        int            e0, o0, guard;
        logic [AW-1:0] snap_addr;
        logic [DW-1:0] snap_data;
        e0 = exp_q.size(); o0 = obs_q.size();
        rsp_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            req_valid = 1'b1; req_addr = AW'(32'h20 + issued);
            @(negedge axis_aclk);
            total++; if (req_ready !== (c < 4)) begin bad++; $display("[TB] FAIL bp_ready c=%0d got=%b exp=%b", c, req_ready, (c < 4)); end
            if (req_ready) issued++;
            if (c == 4) begin snap_addr = rsp_addr; snap_data = rsp_data; end
            if (c > 4) begin
                total++; if (rsp_addr !== snap_addr || rsp_data !== snap_data || rsp_valid !== 1'b1) begin
                    bad++; $display("[TB] FAIL bp_hold c=%0d got v=%b addr=%h data=%h exp v=1 addr=%h data=%h",
                                    c, rsp_valid, rsp_addr, rsp_data, snap_addr, snap_data);
                end
            end
            step();
        end
        total++; if (snap_addr !== 12'h020 || exp_q.size() <= e0 || snap_data !== exp_q[e0].data) begin
            bad++; $display("[TB] FAIL bp_head got addr=%h data=%h exp addr=020 first-lookup content", snap_addr, snap_data);
        end
        rsp_ready = 1'b1;
        guard = 0;
        while ((issued < 6 || (obs_q.size() - o0) < 6) && guard < 30) begin
            req_valid = (issued < 6); req_addr = AW'(32'h20 + issued);
            @(negedge axis_aclk);
            if (req_valid && req_ready) issued++;
            step();
            guard++;
        end
        req_valid = 1'b0;
        total++; if (issued != 6 || (obs_q.size() - o0) != 6 || (exp_q.size() - e0) != 6) begin
            bad++; $display("[TB] FAIL bp_counts got accepted=%0d responses=%0d exp 6/6", issued, obs_q.size() - o0);
        end
        for (int k = 0; k < 6; k++) begin
            if ((o0 + k) < obs_q.size() && (e0 + k) < exp_q.size()) begin
                total++; if (obs_q[o0+k].addr !== AW'(32'h20 + k) || obs_q[o0+k].data !== exp_q[e0+k].data) begin
                    bad++; $display("[TB] FAIL bp_order k=%0d got addr=%h data=%h exp addr=%h data=%h",
                                    k, obs_q[o0+k].addr, obs_q[o0+k].data, AW'(32'h20 + k), exp_q[e0+k].data);
                end
            end
        end
    endtask

    task automatic test_write_priority();
        logic [DW-1:0] d [3];
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 12'h032;
        for (int k = 0; k < 3; k++) begin
            d[k] = rand_data();
            wr_valid = 1'b1; wr_addr = AW'(32'h30 + k); wr_data = d[k];
            @(negedge axis_aclk);
            total++; if (ram_we !== 1'b1 || ram_addr !== wr_addr || ram_din !== d[k] || req_ready !== 1'b0) begin
                bad++; $display("[TB] FAIL prio_k%0d got we=%b addr=%h req_ready=%b exp we=1 addr=%h req_ready=0",
                                k, ram_we, ram_addr, req_ready, wr_addr);
            end
            step();
        end
        wr_valid = 1'b0;
        @(negedge axis_aclk);
        total++; if (req_ready !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 12'h032 || rsp_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL prio_release got ready=%b we=%b addr=%h rsp_valid=%b exp 1/0/032/0",
                            req_ready, ram_we, ram_addr, rsp_valid);
        end
        step();
        req_valid = 1'b0;
        @(negedge axis_aclk);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL prio_lat1 got=%b exp=0", rsp_valid); end
        step();
        @(negedge axis_aclk);
        total++; if (rsp_valid !== 1'b1 || rsp_addr !== 12'h032 || rsp_data !== d[2]) begin
            bad++; $display("[TB] FAIL prio_rsp got v=%b addr=%h data=%h exp v=1 addr=032 data=%h", rsp_valid, rsp_addr, rsp_data, d[2]);
        end
        step();
    endtask

    task automatic test_reset_midop();
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid = 1'b1; req_addr = AW'(32'h40 + k);
            @(negedge axis_aclk);
            total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_accept k=%0d got=%b exp=1", k, req_ready); end
            step();
        end
        req_valid = 1'b0;
        @(negedge axis_aclk);
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL mid_queued got=%b exp=1", rsp_valid); end
        #2 axis_resetn = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0 || rsp_addr !== '0 || rsp_data !== '0) begin
            bad++; $display("[TB] FAIL mid_async_clear got v=%b addr=%h data=%h exp 0/0/0", rsp_valid, rsp_addr, rsp_data);
        end
        step();
        step();
        axis_resetn = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge axis_aclk);
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_stale c=%0d got=%b exp=0", c, rsp_valid); end
            step();
        end
        total++; if ({stat_rd_cnt, stat_wr_cnt, stat_stall_cnt} !== 96'd0) begin
            bad++; $display("[TB] FAIL mid_stats got=%0d/%0d/%0d exp=0/0/0", stat_rd_cnt, stat_wr_cnt, stat_stall_cnt);
        end
    endtask

    task automatic test_stats();
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wr_valid = 1'b1; wr_addr = AW'(32'h50 + k); wr_data = rand_data();
            req_valid = 1'b1; req_addr = 12'h060;
            step();
        end
        req_valid = 1'b0;
        for (int k = 5; k < 10; k++) begin
            wr_addr = AW'(32'h50 + k); wr_data = rand_data();
            step();
        end
        wr_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            req_valid = 1'b1; req_addr = AW'(32'h50 + (k % 10));
            @(negedge axis_aclk);
            total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL stats_accept k=%0d got=%b exp=1", k, req_ready); end
            step();
        end
        req_valid = 1'b0;
        repeat (4) step();
        @(negedge axis_aclk);
        total++; if (stat_wr_cnt !== (STATS_ON ? 32'd10 : 32'd0)) begin
            bad++; $display("[TB] FAIL stat_wr got=%0d exp=%0d", stat_wr_cnt, STATS_ON ? 10 : 0);
        end
        total++; if (stat_rd_cnt !== (STATS_ON ? 32'd20 : 32'd0)) begin
            bad++; $display("[TB] FAIL stat_rd got=%0d exp=%0d", stat_rd_cnt, STATS_ON ? 20 : 0);
        end
        total++; if (stat_stall_cnt !== (STATS_ON ? 32'd5 : 32'd0)) begin
            bad++; $display("[TB] FAIL stat_stall got=%0d exp=%0d", stat_stall_cnt, STATS_ON ? 5 : 0);
        end
        step();
    endtask

    task automatic test_random();
        int e0, o0, guard;
        e0 = exp_q.size(); o0 = obs_q.size();
        for (int c = 0; c < 400; c++) begin
            wr_valid  = ($urandom_range(0, 3) == 0);
            wr_addr   = AW'($urandom_range(0, 15));
            wr_data   = rand_data();
            req_valid = ($urandom_range(0, 9) < 6);
            req_addr  = AW'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 9) < 7);
            @(negedge axis_aclk);
            if (wr_valid) begin
                total++; if (req_ready !== 1'b0 || ram_we !== 1'b1 || ram_addr !== wr_addr) begin
                    bad++; $display("[TB] FAIL rnd_wr_grant c=%0d got ready=%b we=%b addr=%h exp 0/1/%h", c, req_ready, ram_we, ram_addr, wr_addr);
                end
            end
            step();
        end
        wr_valid = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        guard = 0;
        while ((obs_q.size() - o0) < (exp_q.size() - e0) && guard < 20) begin
            step();
            guard++;
        end
        step();
        total++; if ((obs_q.size() - o0) != (exp_q.size() - e0) || rsp_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL rnd_count got=%0d exp=%0d", obs_q.size() - o0, exp_q.size() - e0);
        end
        for (int k = 0; k < exp_q.size() - e0; k++) begin
            if ((o0 + k) < obs_q.size()) begin
                total++; if (obs_q[o0+k].addr !== exp_q[e0+k].addr || obs_q[o0+k].data !== exp_q[e0+k].data) begin
                    bad++; $display("[TB] FAIL rnd_rsp k=%0d got addr=%h data=%h exp addr=%h data=%h",
                                    k, obs_q[o0+k].addr, obs_q[o0+k].data, exp_q[e0+k].addr, exp_q[e0+k].data);
                end
            end
        end
        @(negedge axis_aclk);
        total++; if (stat_wr_cnt !== (STATS_ON ? 32'(n_wr) : 32'd0) || stat_rd_cnt !== (STATS_ON ? 32'(n_rd) : 32'd0)
                     || stat_stall_cnt !== (STATS_ON ? 32'(n_stall) : 32'd0)) begin
            bad++; $display("[TB] FAIL rnd_stats got=%0d/%0d/%0d exp=%0d/%0d/%0d (stats %0d)",
                            stat_rd_cnt, stat_wr_cnt, stat_stall_cnt, n_rd, n_wr, n_stall, STATS_ON);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (2) step();
        test_reset();
        test_write_then_read();
        test_back_to_back();
        test_backpressure();
        test_write_priority();
        test_reset_midop();
        test_stats();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
